// File: rtl/lsu_ctrl.sv
// Load/store unit for the MEM stage. Accepts one load or store from the
// pipeline, runs a ready/valid bus handshake with variable read latency,
// builds byte strobes and lane-aligned write data, and extracts and extends
// load data. Accesses that straddle a bus word are either split into two
// beats or rejected with resp_err, depending on SPLIT_MISALIGN.
module lsu_ctrl #(
  parameter int DATA_W         = 64,
  parameter int ADDR_W         = 64,
  parameter int SPLIT_MISALIGN = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_load,
  input  logic [1:0]            req_size,
  input  logic                  req_unsigned,
  input  logic [ADDR_W-1:0]     req_addr,
  input  logic [DATA_W-1:0]     req_wdata,
  output logic                  resp_valid,
  output logic [DATA_W-1:0]     resp_rdata,
  output logic                  resp_err,
  output logic                  bus_valid,
  input  logic                  bus_ready,
  output logic                  bus_we,
  output logic [ADDR_W-1:0]     bus_addr,
  output logic [DATA_W/8-1:0]   bus_wmask,
  output logic [DATA_W-1:0]     bus_wdata,
  input  logic                  bus_rvalid,
  input  logic [DATA_W-1:0]     bus_rdata
);

  localparam int BYTES = DATA_W / 8;
  localparam int OFF_W = $clog2(BYTES);
  localparam int CW    = OFF_W + 2;
  localparam int MW    = 2 * BYTES;
  localparam int DW2   = 2 * DATA_W;

  typedef enum logic [2:0] {IDLE, REQ0, WAIT0, REQ1, WAIT1, RESP} state_t;

  state_t              state_q, state_d;
  logic                load_q, load_d;
  logic [1:0]          size_q, size_d;
  logic                uns_q, uns_d;
  logic [ADDR_W-1:0]   base_q, base_d;
  logic [OFF_W-1:0]    off_q, off_d;
  logic                cross_q, cross_d;
  logic [MW-1:0]       mask_q, mask_d;
  logic [DW2-1:0]      wdata_q, wdata_d;
  logic [DATA_W-1:0]   beat0_q, beat0_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  logic                err_q, err_d;

  logic [OFF_W-1:0]    reqOff;
  logic [CW-1:0]       reqSizeBytes;
  logic                reqCross;
  logic                reqIllegal;
  logic [MW-1:0]       reqMask;
  logic [DW2-1:0]      reqWdata;

  logic [DW2-1:0]      loadPair;
  logic [DW2-1:0]      loadShifted;
  logic [DATA_W-1:0]   loadLow;
  logic [DATA_W-1:0]   loadKeep;
  logic                loadSign;
  logic [DATA_W-1:0]   loadData;

  // Decode the incoming request: byte offset, word crossing, legality,
  // and the double-width strobe and data images covering both beats.
  always_comb begin
    reqOff       = req_addr[OFF_W-1:0];
    reqSizeBytes = CW'(1) << req_size;
    reqCross     = ({2'b00, reqOff} + reqSizeBytes) > CW'(BYTES);
    reqIllegal   = ((req_size == 2'd3) && (DATA_W == 32)) ||
                   (reqCross && (SPLIT_MISALIGN == 0));
    case (req_size)
      2'd0:    reqMask = MW'(8'h01);
      2'd1:    reqMask = MW'(8'h03);
      2'd2:    reqMask = MW'(8'h0F);
      default: reqMask = MW'(8'hFF);
    endcase
    reqMask  = reqMask << reqOff;
    reqWdata = {{DATA_W{1'b0}}, req_wdata} << {reqOff, 3'b000};
  end

  // Assemble the returned beats, shift the addressed bytes down to bit 0,
  // then zero- or sign-extend according to the latched size.
  always_comb begin
    if (state_q == WAIT1) begin
      loadPair = {bus_rdata, beat0_q};
    end else begin
      loadPair = {{DATA_W{1'b0}}, bus_rdata};
    end
    loadShifted = loadPair >> {off_q, 3'b000};
    loadLow     = loadShifted[DATA_W-1:0];
    case (size_q)
      2'd0: begin
        loadKeep = DATA_W'(8'hFF);
        loadSign = loadLow[7];
      end
      2'd1: begin
        loadKeep = DATA_W'(16'hFFFF);
        loadSign = loadLow[15];
      end
      2'd2: begin
        loadKeep = DATA_W'(32'hFFFF_FFFF);
        loadSign = loadLow[31];
      end
      default: begin
        loadKeep = '1;
        loadSign = 1'b0;
      end
    endcase
    loadData = (loadLow & loadKeep) |
               ({DATA_W{loadSign & ~uns_q}} & ~loadKeep);
  end

  // Next-state and datapath update for the request/beat/response sequence.
  always_comb begin
    state_d = state_q;
    load_d  = load_q;
    size_d  = size_q;
    uns_d   = uns_q;
    base_d  = base_q;
    off_d   = off_q;
    cross_d = cross_q;
    mask_d  = mask_q;
    wdata_d = wdata_q;
    beat0_d = beat0_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          load_d  = req_load;
          size_d  = req_size;
          uns_d   = req_unsigned;
          base_d  = {req_addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
          off_d   = reqOff;
          cross_d = reqCross;
          mask_d  = reqMask;
          wdata_d = reqWdata;
          rdata_d = '0;
          err_d   = reqIllegal;
          state_d = reqIllegal ? RESP : REQ0;
        end
      end
      REQ0: begin
        if (bus_ready) begin
          if (load_q) begin
            state_d = WAIT0;
          end else begin
            state_d = cross_q ? REQ1 : RESP;
          end
        end
      end
      WAIT0: begin
        if (bus_rvalid) begin
          beat0_d = bus_rdata;
          if (cross_q) begin
            state_d = REQ1;
          end else begin
            rdata_d = loadData;
            state_d = RESP;
          end
        end
      end
      REQ1: begin
        if (bus_ready) begin
          state_d = load_q ? WAIT1 : RESP;
        end
      end
      WAIT1: begin
        if (bus_rvalid) begin
          rdata_d = loadData;
          state_d = RESP;
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      load_q  <= 1'b0;
      size_q  <= 2'd0;
      uns_q   <= 1'b0;
      base_q  <= '0;
      off_q   <= '0;
      cross_q <= 1'b0;
      mask_q  <= '0;
      wdata_q <= '0;
      beat0_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      load_q  <= load_d;
      size_q  <= size_d;
      uns_q   <= uns_d;
      base_q  <= base_d;
      off_q   <= off_d;
      cross_q <= cross_d;
      mask_q  <= mask_d;
      wdata_q <= wdata_d;
      beat0_q <= beat0_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  // Outputs decode directly from registered state; bus and response fields
  // are forced to zero outside the states in which they are meaningful.
  assign req_ready  = (state_q == IDLE);
  assign bus_valid  = (state_q == REQ0) || (state_q == REQ1);
  assign bus_we     = bus_valid && !load_q;
  assign bus_addr   = (state_q == REQ1) ? (base_q + ADDR_W'(BYTES)) :
                      (state_q == REQ0) ? base_q : '0;
  assign bus_wmask  = !bus_we ? '0 :
                      (state_q == REQ1) ? mask_q[MW-1:BYTES] : mask_q[BYTES-1:0];
  assign bus_wdata  = !bus_we ? '0 :
                      (state_q == REQ1) ? wdata_q[DW2-1:DATA_W] : wdata_q[DATA_W-1:0];
  assign resp_valid = (state_q == RESP);
  assign resp_rdata = (state_q == RESP) ? rdata_q : '0;
  assign resp_err   = (state_q == RESP) && err_q;

endmodule

// File: tb/tb_lsu_ctrl.sv
// Scoreboard bench for lsu_ctrl: a byte-addressed reference memory predicts
// bus beats and load results, a bus slave model answers the DUT, and two
// extra instances cover the reject paths (no split, 32-bit bus).
module tb_lsu_ctrl;

  localparam int MODE_FAST   = 0;
  localparam int MODE_RANDOM = 1;
  localparam int MODE_STALL  = 2;
  localparam int MODE_HOLD   = 3;

  typedef struct {
    logic [63:0] addr;
    logic        we;
    logic [7:0]  mask;
    logic [63:0] data;
  } beat_t;

  typedef struct {
    logic [63:0] rdata;
    logic        err;
    int          lat;
    int          startCyc;
  } resp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        reqValid, reqReady, reqLoad, reqUns;
  logic [1:0]  reqSize;
  logic [63:0] reqAddr, reqWdata;
  logic        respValid, respErr;
  logic [63:0] respRdata;
  logic        busValid, busReady, busWe, busRvalid;
  logic [63:0] busAddr, busWdata, busRdata;
  logic [7:0]  busWmask;

  logic        sideLoad, sideUns, sideBusReady, sideRvalid;
  logic [1:0]  sideSize;
  logic [63:0] sideAddr, sideWdata, sideRdata;
  logic        nsReqValid, nsReqReady, nsRespValid, nsRespErr, nsBusValid, nsBusWe;
  logic [63:0] nsRespRdata, nsBusAddr, nsBusWdata;
  logic [7:0]  nsBusWmask;
  logic        w32ReqValid, w32ReqReady, w32RespValid, w32RespErr, w32BusValid, w32BusWe;
  logic [31:0] w32RespRdata, w32BusAddr, w32BusWdata;
  logic [3:0]  w32BusWmask;

  beat_t       beatQ[$];
  resp_t       respQ[$];
  logic [7:0]  busMem [logic [63:0]];
  logic [7:0]  refMem [logic [63:0]];
  int          total = 0;
  int          bad = 0;
  int          cyc = 0;
  int          slaveMode = MODE_FAST;
  bit          injectRvalid = 1'b0;

  lsu_ctrl #(.DATA_W(64), .ADDR_W(64), .SPLIT_MISALIGN(1)) dut (
    .clk(clk), .rst(rst), .req_valid(reqValid), .req_ready(reqReady),
    .req_load(reqLoad), .req_size(reqSize), .req_unsigned(reqUns),
    .req_addr(reqAddr), .req_wdata(reqWdata), .resp_valid(respValid),
    .resp_rdata(respRdata), .resp_err(respErr), .bus_valid(busValid),
    .bus_ready(busReady), .bus_we(busWe), .bus_addr(busAddr),
    .bus_wmask(busWmask), .bus_wdata(busWdata), .bus_rvalid(busRvalid),
    .bus_rdata(busRdata));

  lsu_ctrl #(.DATA_W(64), .ADDR_W(64), .SPLIT_MISALIGN(0)) dutNs (
    .clk(clk), .rst(rst), .req_valid(nsReqValid), .req_ready(nsReqReady),
    .req_load(sideLoad), .req_size(sideSize), .req_unsigned(sideUns),
    .req_addr(sideAddr), .req_wdata(sideWdata), .resp_valid(nsRespValid),
    .resp_rdata(nsRespRdata), .resp_err(nsRespErr), .bus_valid(nsBusValid),
    .bus_ready(sideBusReady), .bus_we(nsBusWe), .bus_addr(nsBusAddr),
    .bus_wmask(nsBusWmask), .bus_wdata(nsBusWdata), .bus_rvalid(sideRvalid),
    .bus_rdata(sideRdata));

  lsu_ctrl #(.DATA_W(32), .ADDR_W(32), .SPLIT_MISALIGN(1)) dut32 (
    .clk(clk), .rst(rst), .req_valid(w32ReqValid), .req_ready(w32ReqReady),
    .req_load(sideLoad), .req_size(sideSize), .req_unsigned(sideUns),
    .req_addr(sideAddr[31:0]), .req_wdata(sideWdata[31:0]), .resp_valid(w32RespValid),
    .resp_rdata(w32RespRdata), .resp_err(w32RespErr), .bus_valid(w32BusValid),
    .bus_ready(sideBusReady), .bus_we(w32BusWe), .bus_addr(w32BusAddr),
    .bus_wmask(w32BusWmask), .bus_wdata(w32BusWdata), .bus_rvalid(sideRvalid),
    .bus_rdata(sideRdata[31:0]));

  always #5 clk = ~clk;

  // Cycle counter used to measure response latency.
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [7:0] initByte(logic [63:0] a);
    return a[7:0] ^ a[15:8] ^ 8'h5A;
  endfunction

  function automatic logic [7:0] busByte(logic [63:0] a);
    return busMem.exists(a) ? busMem[a] : initByte(a);
  endfunction

  function automatic logic [7:0] refByte(logic [63:0] a);
    return refMem.exists(a) ? refMem[a] : initByte(a);
  endfunction

  function automatic logic [63:0] readWord(logic [63:0] a);
    logic [63:0] w;
    for (int i = 0; i < 8; i++) w[i*8 +: 8] = busByte(a + 64'(i));
    return w;
  endfunction

  function automatic void checkOutput(string name, logic [63:0] act, logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endfunction

  task automatic preloadWord(input logic [63:0] a, input logic [63:0] w);
    for (int i = 0; i < 8; i++) begin
      busMem[a + 64'(i)] = w[i*8 +: 8];
      refMem[a + 64'(i)] = w[i*8 +: 8];
    end
  endtask

  // Reference model: walk the access byte by byte, bin each byte into the
  // bus word it lives in, and read or update the reference memory.
  task automatic pushExpect(input bit load, input logic [1:0] size, input bit uns,
                            input logic [63:0] addr, input logic [63:0] wdata,
                            input bit useExp, input logic [63:0] expRdata);
    int          n = 1 << size;
    logic [63:0] w0 = addr & ~64'h7;
    logic [63:0] ba, val, d0, d1;
    logic [7:0]  m0, m1;
    bit          split = 1'b0;
    int          lane;
    beat_t       b;
    resp_t       r;
    val = '0; d0 = '0; d1 = '0; m0 = '0; m1 = '0;
    for (int i = 0; i < n; i++) begin
      ba = addr + 64'(i);
      lane = int'(ba[2:0]);
      if ((ba & ~64'h7) == w0) begin
        m0[lane] = 1'b1;
        d0[lane*8 +: 8] = wdata[i*8 +: 8];
      end else begin
        split = 1'b1;
        m1[lane] = 1'b1;
        d1[lane*8 +: 8] = wdata[i*8 +: 8];
      end
      if (load) val[i*8 +: 8] = refByte(ba);
      else refMem[ba] = wdata[i*8 +: 8];
    end
    if (load && !uns && n < 8 && val[8*n-1]) val = val | ~((64'd1 << (8*n)) - 64'd1);
    b.addr = w0; b.we = !load; b.mask = m0; b.data = d0;
    beatQ.push_back(b);
    if (split) begin
      b.addr = w0 + 64'd8; b.mask = m1; b.data = d1;
      beatQ.push_back(b);
    end
    r.rdata = !load ? 64'd0 : (useExp ? expRdata : val);
    r.err = 1'b0;
    r.lat = (slaveMode == MODE_FAST) ? 1 + (split ? 2 : 1) * (load ? 2 : 1) : -1;
    r.startCyc = cyc;
    respQ.push_back(r);
  endtask

  // Issue one request once the unit is idle, then hold a junk request for
  // one more edge while the unit is busy; it must be ignored.
  task automatic applyStimulus(input bit load, input logic [1:0] size, input bit uns,
                               input logic [63:0] addr, input logic [63:0] wdata,
                               input bit useExp, input logic [63:0] expRdata);
    int waitCyc = 0;
    @(negedge clk);
    while (!reqReady && waitCyc < 200) begin
      @(negedge clk);
      waitCyc++;
    end
    if (!reqReady) begin
      total++; bad++;
      $display("[TB] FAIL req_ready_timeout: got 0 expected 1");
      return;
    end
    pushExpect(load, size, uns, addr, wdata, useExp, expRdata);
    reqValid = 1'b1; reqLoad = load; reqSize = size; reqUns = uns;
    reqAddr = addr; reqWdata = wdata;
    @(posedge clk); #1;
    reqAddr = 64'h2000; reqLoad = ~load;
    @(posedge clk); #1;
    reqValid = 1'b0;
  endtask

  task automatic randomReq();
    applyStimulus(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
                  1'($urandom_range(0, 1)), 64'h1000 + 64'($urandom_range(0, 47)),
                  {$urandom, $urandom}, 1'b0, 64'd0);
  endtask

  task automatic waitDrain();
    int n = 0;
    while ((respQ.size() != 0 || beatQ.size() != 0) && n < 1000) begin
      @(negedge clk);
      n++;
    end
    if (respQ.size() != 0 || beatQ.size() != 0) begin
      total++; bad++;
      $display("[TB] FAIL drain_timeout: got %0d pending expected 0", respQ.size() + beatQ.size());
    end
  endtask

  // Drive one request into a side instance with an always-ready bus and no
  // read returns; count beats and responses over a fixed window.
  task automatic checkSide(input bit use32, input bit load, input logic [1:0] size,
                           input logic [63:0] addr, input int expBeats, input bit expErr);
    int beats = 0, resps = 0;
    @(negedge clk);
    sideLoad = load; sideSize = size; sideAddr = addr; sideWdata = 64'hDEADBEEF;
    if (use32) w32ReqValid = 1'b1; else nsReqValid = 1'b1;
    @(posedge clk); #1;
    w32ReqValid = 1'b0; nsReqValid = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (use32 ? w32BusValid : nsBusValid) beats++;
      if (use32 ? w32RespValid : nsRespValid) begin
        resps++;
        checkOutput("side_resp_err", use32 ? w32RespErr : nsRespErr, expErr);
        checkOutput("side_resp_rdata", use32 ? 64'(w32RespRdata) : nsRespRdata, 64'd0);
        checkOutput("side_resp_cycle", i, expBeats);
      end
    end
    checkOutput("side_beat_count", beats, expBeats);
    checkOutput("side_resp_count", resps, 1);
  endtask

  // Bus slave: chooses ready per mode, returns read data after a delay,
  // and checks every accepted beat against the scoreboard.
  initial begin
    bit          pendValid = 1'b0;
    int          pendDelay = 0;
    logic [63:0] pendAddr = '0;
    logic [63:0] laneMask;
    beat_t       e;
    busReady = 1'b0; busRvalid = 1'b0; busRdata = '0;
    forever begin
      @(posedge clk); #1;
      busRvalid = 1'b0;
      if (injectRvalid) begin
        busRvalid = 1'b1;
        busRdata = {$urandom, $urandom};
        injectRvalid = 1'b0;
      end else if (pendValid) begin
        if (pendDelay == 0) begin
          busRvalid = 1'b1;
          busRdata = readWord(pendAddr);
          pendValid = 1'b0;
        end else begin
          pendDelay--;
        end
      end
      case (slaveMode)
        MODE_RANDOM: busReady = ($urandom_range(0, 9) < 6);
        MODE_STALL:  busReady = 1'b0;
        default:     busReady = 1'b1;
      endcase
      @(negedge clk);
      if (busValid && busReady && !rst) begin
        if (beatQ.size() == 0) begin
          total++; bad++;
          $display("[TB] FAIL unexpected_beat: got addr %h expected no beat", busAddr);
        end else begin
          e = beatQ.pop_front();
          checkOutput("beat_addr", busAddr, e.addr);
          checkOutput("beat_we", busWe, e.we);
          if (e.we) begin
            for (int i = 0; i < 8; i++) laneMask[i*8 +: 8] = {8{e.mask[i]}};
            checkOutput("beat_mask", busWmask, e.mask);
            checkOutput("beat_wdata", busWdata & laneMask, e.data & laneMask);
          end
        end
        if (busWe) begin
          for (int i = 0; i < 8; i++)
            if (busWmask[i]) busMem[busAddr + 64'(i)] = busWdata[i*8 +: 8];
        end else if (slaveMode != MODE_HOLD) begin
          pendValid = 1'b1;
          pendAddr = busAddr;
          pendDelay = (slaveMode == MODE_FAST) ? 0 : $urandom_range(0, 3);
        end
      end
    end
  end

  // Response monitor: every completion pulse must match the oldest
  // outstanding expectation.
  initial begin
    resp_t e;
    forever begin
      @(negedge clk);
      if (respValid) begin
        if (respQ.size() == 0) begin
          total++; bad++;
          $display("[TB] FAIL spurious_resp: got resp_valid 1 expected 0");
        end else begin
          e = respQ.pop_front();
          checkOutput("resp_rdata", respRdata, e.rdata);
          checkOutput("resp_err", respErr, e.err);
          if (e.lat >= 0) checkOutput("resp_latency", cyc - e.startCyc, e.lat);
        end
      end
    end
  end

  // Main sequence: reset, directed scenarios, random traffic, stall,
  // reset during a read, and the reject paths on the side instances.
  initial begin
    rst = 1'b1;
    reqValid = 1'b0; reqLoad = 1'b0; reqSize = 2'd0; reqUns = 1'b0;
    reqAddr = '0; reqWdata = '0;
    sideLoad = 1'b0; sideUns = 1'b0; sideSize = 2'd0; sideAddr = '0; sideWdata = '0;
    sideBusReady = 1'b1; sideRvalid = 1'b0; sideRdata = '0;
    nsReqValid = 1'b0; w32ReqValid = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("reset_req_ready", reqReady, 1);
    checkOutput("reset_bus_valid", busValid, 0);
    checkOutput("reset_resp_valid", respValid, 0);
    checkOutput("reset_resp_rdata", respRdata, 0);
    checkOutput("reset_bus_addr", busAddr, 0);
    checkOutput("reset_bus_wmask", busWmask, 0);
    checkOutput("reset_ns_ready", nsReqReady, 1);
    checkOutput("reset_w32_ready", w32ReqReady, 1);
    rst = 1'b0;

    preloadWord(64'h1000, 64'h8000_0001_1234_5678);
    applyStimulus(1, 2'd2, 0, 64'h1004, 64'd0, 1, 64'hFFFF_FFFF_8000_0001);
    applyStimulus(1, 2'd2, 1, 64'h1004, 64'd0, 1, 64'h0000_0000_8000_0001);
    applyStimulus(0, 2'd1, 0, 64'h1006, 64'hABCD, 0, 64'd0);
    waitDrain();
    preloadWord(64'h1000, 64'h8877_6655_4433_2211);
    preloadWord(64'h1008, 64'hFFEE_DDCC_BBAA_9900);
    applyStimulus(1, 2'd3, 0, 64'h1003, 64'd0, 1, 64'hAA99_0088_7766_5544);
    applyStimulus(0, 2'd2, 0, 64'h100E, 64'hDEADBEEF, 0, 64'd0);
    applyStimulus(1, 2'd3, 0, 64'hFFFF_FFFF_FFFF_FFFC, 64'd0, 0, 64'd0);
    waitDrain();

    for (int i = 0; i < 150; i++) randomReq();
    waitDrain();
    slaveMode = MODE_RANDOM;
    for (int i = 0; i < 150; i++) randomReq();
    waitDrain();

    slaveMode = MODE_STALL;
    applyStimulus(0, 2'd1, 0, 64'h1006, 64'hABCD, 0, 64'd0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checkOutput("stall_bus_valid", busValid, 1);
      checkOutput("stall_bus_addr", busAddr, 64'h1000);
      checkOutput("stall_bus_wmask", busWmask, 8'hC0);
      checkOutput("stall_bus_wdata", busWdata, 64'hABCD_0000_0000_0000);
    end
    slaveMode = MODE_FAST;
    waitDrain();

    slaveMode = MODE_HOLD;
    applyStimulus(1, 2'd3, 0, 64'h1000, 64'd0, 0, 64'd0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    checkOutput("abort_req_ready", reqReady, 1);
    checkOutput("abort_bus_valid", busValid, 0);
    rst = 1'b0;
    respQ.delete();
    slaveMode = MODE_FAST;
    injectRvalid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checkOutput("abort_no_resp", respValid, 0);
    end
    applyStimulus(1, 2'd2, 1, 64'h1010, 64'd0, 0, 64'd0);
    waitDrain();

    checkSide(0, 0, 2'd2, 64'h100E, 0, 1);
    checkSide(0, 0, 2'd1, 64'h1009, 1, 0);
    checkSide(1, 1, 2'd3, 64'h0100, 0, 1);
    checkSide(1, 0, 2'd2, 64'h0102, 2, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
